// File: rtl/gray_step_if.sv
// Bundle between a Gray-code sample source and gray_step_tracker.
// The master drives the sample strobe and Gray value; the slave returns the decoded state.
interface gray_step_if #(
  parameter int POS_W    = 8,
  parameter int ERRCNT_W = 8
);
  logic                en;
  logic [2:0]          gray_in;
  logic                clr_err;
  logic [2:0]          bin;
  logic [POS_W-1:0]    pos;
  logic                dir;
  logic                step;
  logic                err;
  logic [ERRCNT_W-1:0] err_count;
  logic                locked;

  modport master (
    output en, gray_in, clr_err,
    input  bin, pos, dir, step, err, err_count, locked
  );

  modport slave (
    input  en, gray_in, clr_err,
    output bin, pos, dir, step, err, err_count, locked
  );
endinterface

// File: rtl/gray_step_tracker.sv
// Tracks a 3-bit Gray-code counter: decodes each sample, counts +/-1 steps into a
// signed position, flags illegal jumps, and drops lock after repeated bad jumps.
module gray_step_tracker #(
  parameter int POS_W     = 8,
  parameter int ERRCNT_W  = 8,
  parameter int ERR_LIMIT = 3
) (
  input logic       clk,
  input logic       reset,
  gray_step_if.slave bus
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [2:0] LIM = 3'(ERR_LIMIT);

  state_t              state_q, state_d;
  logic [2:0]          bin_q, bin_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic                locked_q, locked_d;
  logic [2:0]          cerr_q, cerr_d;

  logic [2:0] b_new;
  logic [2:0] delta;
  logic [2:0] cerr_inc;
  logic       illegal;

  assign bus.bin       = bin_q;
  assign bus.pos       = pos_q;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.locked    = locked_q;

  // Decode the sample and classify it against the last accepted value.
  always_comb begin
    b_new[2] = bus.gray_in[2];
    b_new[1] = bus.gray_in[2] ^ bus.gray_in[1];
    b_new[0] = b_new[1] ^ bus.gray_in[0];
    delta    = b_new - bin_q;
    cerr_inc = cerr_q + 3'd1;
    illegal  = 1'b0;

    state_d     = state_q;
    bin_d       = bin_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    locked_d    = locked_q;
    cerr_d      = cerr_q;

    if (bus.en) begin
      if (state_q == UNLOCKED) begin
        bin_d    = b_new;
        locked_d = 1'b1;
        cerr_d   = '0;
        state_d  = LOCKED;
      end else begin
        unique case (delta)
          3'd0: cerr_d = '0;
          3'd1: begin
            pos_d  = pos_q + POS_W'(1);
            dir_d  = 1'b1;
            step_d = 1'b1;
            bin_d  = b_new;
            cerr_d = '0;
          end
          3'd7: begin
            pos_d  = pos_q - POS_W'(1);
            dir_d  = 1'b0;
            step_d = 1'b1;
            bin_d  = b_new;
            cerr_d = '0;
          end
          default: begin
            illegal = 1'b1;
            err_d   = 1'b1;
            bin_d   = b_new;
            if (err_count_q != '1)
              err_count_d = err_count_q + ERRCNT_W'(1);
            if (cerr_inc == LIM) begin
              state_d  = UNLOCKED;
              locked_d = 1'b0;
              cerr_d   = '0;
            end else begin
              cerr_d = cerr_inc;
            end
          end
        endcase
      end
    end

    if (bus.clr_err)
      err_count_d = illegal ? ERRCNT_W'(1) : '0;
  end

  // Register all state and outputs; reset wins over any in-flight sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      bin_q       <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b1;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      cerr_q      <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      cerr_q      <= cerr_d;
    end
  end

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed test of gray_step_tracker with hand-computed expectations.
// Each task drives one scenario and checks its own results.
module tb_gray_step_tracker;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nmis = 0;

  gray_step_if #(.POS_W(8), .ERRCNT_W(8)) bus ();

  gray_step_tracker #(
    .POS_W(8), .ERRCNT_W(8), .ERR_LIMIT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic e, input logic [2:0] g, input logic c);
    bus.en = e; bus.gray_in = g; bus.clr_err = c;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 3'b000, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (bus.bin !== 3'd0) begin nmis++; $display("FAIL rst_bin got %0d exp 0", bus.bin); end
    nvec++; if (bus.pos !== 8'h00) begin nmis++; $display("FAIL rst_pos got %h exp 00", bus.pos); end
    nvec++; if (bus.dir !== 1'b1) begin nmis++; $display("FAIL rst_dir got %b exp 1", bus.dir); end
    nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL rst_locked got %b exp 0", bus.locked); end
    nvec++; if ({bus.step, bus.err} !== 2'b00) begin nmis++; $display("FAIL rst_pulses got %b exp 00", {bus.step, bus.err}); end
    nvec++; if (bus.err_count !== 8'd0) begin nmis++; $display("FAIL rst_errcnt got %0d exp 0", bus.err_count); end
  endtask

  task automatic test_up_sequence();
    logic [2:0] seq [8];
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    nvec++; if (bus.locked !== 1'b1) begin nmis++; $display("FAIL lock_locked got %b exp 1", bus.locked); end
    nvec++; if (bus.step !== 1'b0) begin nmis++; $display("FAIL lock_step got %b exp 0", bus.step); end
    nvec++; if (bus.pos !== 8'h00) begin nmis++; $display("FAIL lock_pos got %h exp 00", bus.pos); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, seq[i], 1'b0);
      nvec++; if ({bus.step, bus.err} !== 2'b10) begin nmis++; $display("FAIL up_pulse[%0d] got %b exp 10", i, {bus.step, bus.err}); end
    end
    nvec++; if (bus.pos !== 8'd8) begin nmis++; $display("FAIL up_pos got %h exp 08", bus.pos); end
    nvec++; if (bus.dir !== 1'b1) begin nmis++; $display("FAIL up_dir got %b exp 1", bus.dir); end
    nvec++; if (bus.bin !== 3'd0) begin nmis++; $display("FAIL up_bin got %0d exp 0", bus.bin); end
    tick(1'b0, 3'b011, 1'b0);
    nvec++; if (bus.step !== 1'b0) begin nmis++; $display("FAIL up_idle_step got %b exp 0", bus.step); end
    nvec++; if (bus.bin !== 3'd0) begin nmis++; $display("FAIL up_idle_bin got %0d exp 0", bus.bin); end
  endtask

  task automatic test_down();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b100, 1'b0);
    nvec++; if (bus.step !== 1'b1) begin nmis++; $display("FAIL dn_step0 got %b exp 1", bus.step); end
    tick(1'b1, 3'b101, 1'b0);
    nvec++; if (bus.step !== 1'b1) begin nmis++; $display("FAIL dn_step1 got %b exp 1", bus.step); end
    tick(1'b1, 3'b111, 1'b0);
    nvec++; if (bus.step !== 1'b1) begin nmis++; $display("FAIL dn_step2 got %b exp 1", bus.step); end
    nvec++; if (bus.dir !== 1'b0) begin nmis++; $display("FAIL dn_dir got %b exp 0", bus.dir); end
    nvec++; if (bus.pos !== 8'hFD) begin nmis++; $display("FAIL dn_pos got %h exp fd", bus.pos); end
    nvec++; if (bus.bin !== 3'd5) begin nmis++; $display("FAIL dn_bin got %0d exp 5", bus.bin); end
    tick(1'b1, 3'b111, 1'b0);
    nvec++; if ({bus.step, bus.err, bus.pos} !== {2'b00, 8'hFD}) begin nmis++; $display("FAIL dn_hold got %b/%h exp 00/fd", {bus.step, bus.err}, bus.pos); end
  endtask

  task automatic test_illegal();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b011, 1'b0);
    nvec++; if ({bus.err, bus.step} !== 2'b10) begin nmis++; $display("FAIL ill_pulse got %b exp 10", {bus.err, bus.step}); end
    nvec++; if (bus.err_count !== 8'd1) begin nmis++; $display("FAIL ill_errcnt got %0d exp 1", bus.err_count); end
    nvec++; if (bus.pos !== 8'h00) begin nmis++; $display("FAIL ill_pos got %h exp 00", bus.pos); end
    nvec++; if (bus.bin !== 3'd2) begin nmis++; $display("FAIL ill_bin got %0d exp 2", bus.bin); end
    nvec++; if (bus.locked !== 1'b1) begin nmis++; $display("FAIL ill_locked got %b exp 1", bus.locked); end
    tick(1'b0, 3'b010, 1'b0);
    nvec++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL ill_onecycle got %b exp 0", bus.err); end
    tick(1'b1, 3'b010, 1'b0);
    nvec++; if ({bus.step, bus.pos} !== {1'b1, 8'h01}) begin nmis++; $display("FAIL ill_recover got %b/%h exp 1/01", bus.step, bus.pos); end
  endtask

  task automatic test_lose_lock();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b011, 1'b0);
    tick(1'b1, 3'b111, 1'b0);
    nvec++; if ({bus.err, bus.locked} !== 2'b11) begin nmis++; $display("FAIL ll_second got %b exp 11", {bus.err, bus.locked}); end
    tick(1'b1, 3'b001, 1'b0);
    nvec++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL ll_third_err got %b exp 1", bus.err); end
    nvec++; if (bus.err_count !== 8'd3) begin nmis++; $display("FAIL ll_errcnt got %0d exp 3", bus.err_count); end
    nvec++; if (bus.locked !== 1'b0) begin nmis++; $display("FAIL ll_locked got %b exp 0", bus.locked); end
    tick(1'b1, 3'b011, 1'b0);
    nvec++; if ({bus.locked, bus.step, bus.err} !== 3'b100) begin nmis++; $display("FAIL ll_relock got %b exp 100", {bus.locked, bus.step, bus.err}); end
    nvec++; if ({bus.bin, bus.pos} !== {3'd2, 8'h00}) begin nmis++; $display("FAIL ll_relock_val got %0d/%h exp 2/00", bus.bin, bus.pos); end
  endtask

  task automatic test_wrap_and_clr();
    logic [2:0] b;
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 1; i <= 127; i++) begin
      b = 3'(i);
      tick(1'b1, b ^ (b >> 1), 1'b0);
    end
    nvec++; if (bus.pos !== 8'h7F) begin nmis++; $display("FAIL wrap_pre got %h exp 7f", bus.pos); end
    tick(1'b1, 3'b000, 1'b0);
    nvec++; if ({bus.step, bus.pos} !== {1'b1, 8'h80}) begin nmis++; $display("FAIL wrap_pos got %b/%h exp 1/80", bus.step, bus.pos); end
    tick(1'b1, 3'b010, 1'b0);
    nvec++; if (bus.err_count !== 8'd1) begin nmis++; $display("FAIL clr_pre got %0d exp 1", bus.err_count); end
    tick(1'b0, 3'b010, 1'b1);
    nvec++; if (bus.err_count !== 8'd0) begin nmis++; $display("FAIL clr_alone got %0d exp 0", bus.err_count); end
    tick(1'b1, 3'b101, 1'b0);
    tick(1'b1, 3'b000, 1'b1);
    nvec++; if ({bus.err, bus.err_count} !== {1'b1, 8'd1}) begin nmis++; $display("FAIL clr_ill got %b/%0d exp 1/1", bus.err, bus.err_count); end
    nvec++; if (bus.pos !== 8'h80) begin nmis++; $display("FAIL clr_pos got %h exp 80", bus.pos); end
  endtask

  task automatic test_mid_reset();
    logic [2:0] b;
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      b = 3'(i);
      tick(1'b1, b ^ (b >> 1), 1'b0);
    end
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b1, 3'b110, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'b101, 1'b0);
      nvec++; if ({bus.pos, bus.err_count, bus.step, bus.err, bus.bin} !== {8'd5, 8'd2, 2'b00, 3'd4}) begin
        nmis++; $display("FAIL idle[%0d] got pos %h cnt %0d pulses %b bin %0d exp 05/2/00/4", i, bus.pos, bus.err_count, {bus.step, bus.err}, bus.bin);
      end
    end
    reset = 1'b1;
    tick(1'b1, 3'b101, 1'b0);
    reset = 1'b0;
    nvec++; if ({bus.bin, bus.pos, bus.dir} !== {3'd0, 8'h00, 1'b1}) begin nmis++; $display("FAIL mr_state got %0d/%h/%b exp 0/00/1", bus.bin, bus.pos, bus.dir); end
    nvec++; if ({bus.step, bus.err, bus.locked, bus.err_count} !== {3'b000, 8'd0}) begin nmis++; $display("FAIL mr_flags got %b/%0d exp 000/0", {bus.step, bus.err, bus.locked}, bus.err_count); end
    tick(1'b1, 3'b001, 1'b0);
    nvec++; if ({bus.locked, bus.step, bus.bin} !== {2'b10, 3'd1}) begin nmis++; $display("FAIL mr_relock got %b/%0d exp 10/1", {bus.locked, bus.step}, bus.bin); end
  endtask

  initial begin
    reset = 1'b0;
    bus.en = 1'b0; bus.gray_in = 3'b000; bus.clr_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_up_sequence();
    test_down();
    test_illegal();
    test_lose_lock();
    test_wrap_and_clr();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
